cache_bank_arbiter: RTL and testbench
=====================================

Name: cache_bank_arbiter

Overview:
- Shares one dual-port cache bank (ports A/B) among NUM_REQ requesters with round-robin priority.
- Grants up to two requests per cycle, one per bank port, and suppresses same-address hazards.
- Registers the bank-side command and returns read data and write acks to the owning requester after a fixed latency.
- Sits between the core-side load/store units and the cache bank.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, bank word width
ADDR_WIDTH, 8, bank address width
RD_LAT, 1, cycles from bank command registered to bank read data valid (1..4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  request pending, one bit per requester
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
gnt  out  NUM_REQ  combinational one-cycle accept pulse
rsp_valid  out  NUM_REQ  registered response pulse
rsp_data  out  NUM_REQ*DATA_WIDTH  read data; 0 for write acks
bank_addr_A / bank_addr_B  out  ADDR_WIDTH  bank port addresses
bank_din_A / bank_din_B  out  DATA_WIDTH  bank write data
bank_we_A / bank_we_B  out  1  bank write enables
bank_dout_A / bank_dout_B  in  DATA_WIDTH  bank read data

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs go to 0 (bank_*, rsp_valid, rsp_data). Round-robin pointer ptr=0. Pipeline tags are cleared, so in-flight responses are dropped. gnt is 0 while reset is asserted.
- Requester rule: hold req, we, addr and wdata stable until gnt=1. The request is consumed in the gnt cycle. req may be deasserted in the cycle after gnt.
- Arbitration (combinational, cycle t):
  - Scan requesters ptr, ptr+1, … (mod NUM_REQ).
  - The first pending requester wins port A.
  - Scanning continues for port B. Skip any candidate whose addr equals the port-A address when either request is a write. The first non-conflicting candidate wins port B.
  - Two reads to the same address are both granted.
  - A requester is never granted twice in one cycle.
- ptr update at t+1: (index of last granted requester + 1) mod NUM_REQ. If nothing is granted, ptr is unchanged.
- Bank command (registered, visible t+1): granted addr, wdata and we drive the bank ports.
  - An unused port drives addr=0, din=0, we=0.
- Response:
  - Per-port tag pipeline of depth RD_LAT+1 carries {valid, requester id}.
  - rsp_valid[id] pulses for one cycle at t+1+RD_LAT.
  - Reads: rsp_data slice = bank_dout of that port, sampled in the same cycle.
  - Writes: rsp_data slice = 0.
- Back-to-back: a new grant is allowed every cycle. The pipeline is fully pipelined with no bubbles.
- Responses to the same requester return in grant order. Two responses in one cycle only occur for different requesters.
- Read-after-write in the following cycle to the same address is not forwarded. Returned data is whatever the bank returns.

Optional Feature:
- Macro: CACHE_ARB_PERF_EN.
- Defined: adds output conflict_cnt [15:0], a registered counter with reset value 0.
  - Increments by 1 in each cycle in which at least one pending requester was skipped for port B because of an address hazard.
  - Saturates at 16'hFFFF.
- Undefined: port and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset mid-flight: grant read at t, assert reset at t+1 -> no rsp_valid follows. After release, ptr=0 and all bank_we are 0.
- Single read: req=4'b0001, addr0=8'h04, bank returns 8'h02 on A -> gnt=0001 at t; bank_addr_A=8'h04 at t+1; rsp_valid=0001, rsp_data0=8'h02 at t+2 (RD_LAT=1).
- Dual grant: req=1111, all reads to distinct addresses, ptr=0 -> gnt=0011, ptr becomes 2; next cycle gnt=1100, ptr becomes 0.
- Write hazard: r0 write addr 8'h06 data 8'h03, r1 read addr 8'h06, r2 read addr 8'h07 -> gnt=0101, r1 granted next cycle; conflict_cnt=1 if CACHE_ARB_PERF_EN is defined.
- Same-address reads: r0 and r1 read 8'h01 -> gnt=0011 in the same cycle, and both rsp_data equal the bank value.
- Fairness: hold req=1111 for 8 cycles -> each requester granted exactly 4 times, and no requester waits more than 2 cycles.

Source files
------------

// File: rtl/cache_bank_arbiter.sv
// cache_bank_arbiter: shares one dual-port cache bank among NUM_REQ requesters.
// Round-robin scan picks up to two requests per cycle (port A, then port B),
// skipping port-B candidates that would form a write hazard with port A.
// Bank commands are registered; responses return RD_LAT+1 cycles after grant.
// Optional build macro CACHE_ARB_PERF_EN adds the conflict_cnt_o hazard counter.
module cache_bank_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ-1:0]             req_we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]             gnt_o,
   output logic [NUM_REQ-1:0]             rsp_valid_o,
   output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_data_o,
   output logic [ADDR_WIDTH-1:0]          bank_addr_a_o,
   output logic [ADDR_WIDTH-1:0]          bank_addr_b_o,
   output logic [DATA_WIDTH-1:0]          bank_din_a_o,
   output logic [DATA_WIDTH-1:0]          bank_din_b_o,
   output logic                           bank_we_a_o,
   output logic                           bank_we_b_o,
   input  logic [DATA_WIDTH-1:0]          bank_dout_a_i,
   input  logic [DATA_WIDTH-1:0]          bank_dout_b_i
`ifdef CACHE_ARB_PERF_EN
   ,
   output logic [15:0]                    conflict_cnt_o
`endif
);

   localparam int IDW = $clog2(NUM_REQ);

   // round-robin pointer
   logic [IDW-1:0]        ptr_q, ptr_d;

   // unpacked request fields and scan order
   logic [ADDR_WIDTH-1:0] addr_w  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_w [NUM_REQ];
   logic [IDW-1:0]        scan_id [NUM_REQ];

   // arbitration result
   logic                  a_vld, b_vld;
   logic [IDW-1:0]        a_id, b_id;
   logic [IDW-1:0]        last_id;

   // bank command registers
   logic [ADDR_WIDTH-1:0] bank_addr_a_q, bank_addr_a_d, bank_addr_b_q, bank_addr_b_d;
   logic [DATA_WIDTH-1:0] bank_din_a_q, bank_din_a_d, bank_din_b_q, bank_din_b_d;
   logic                  bank_we_a_q, bank_we_a_d, bank_we_b_q, bank_we_b_d;

   // per-port tag pipeline: stages 0..RD_LAT-1, final stage is the response register
   logic                  tag_a_vld_q [RD_LAT];
   logic                  tag_a_we_q  [RD_LAT];
   logic [IDW-1:0]        tag_a_id_q  [RD_LAT];
   logic                  tag_b_vld_q [RD_LAT];
   logic                  tag_b_we_q  [RD_LAT];
   logic [IDW-1:0]        tag_b_id_q  [RD_LAT];

   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0]    rsp_from_b_q, rsp_from_b_d;
   logic [NUM_REQ-1:0]    rsp_rd_q, rsp_rd_d;

`ifdef CACHE_ARB_PERF_EN
   logic                  hazard_skip;
   logic [15:0]           conflict_cnt_q;
`endif

   // unpack requester fields and build the scan order starting at ptr
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign addr_w[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_w[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sum         = {1'b0, ptr_q} + (IDW+1)'(gi);
      assign scan_id[gi] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                      : sum[IDW-1:0];
   end

   // round-robin scan: first pending wins A, first hazard-free later one wins B
   always_comb begin
      a_vld = 1'b0;
      b_vld = 1'b0;
      a_id  = '0;
      b_id  = '0;
`ifdef CACHE_ARB_PERF_EN
      hazard_skip = 1'b0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_i[scan_id[k]]) begin
            if (!a_vld) begin
               a_vld = 1'b1;
               a_id  = scan_id[k];
            end else if (!b_vld) begin
               if (!((addr_w[scan_id[k]] == addr_w[a_id]) &&
                     (req_we_i[scan_id[k]] || req_we_i[a_id]))) begin
                  b_vld = 1'b1;
                  b_id  = scan_id[k];
               end
`ifdef CACHE_ARB_PERF_EN
               else begin
                  hazard_skip = 1'b1;
               end
`endif
            end
         end
      end
   end

   // grant pulses, pointer advance and next bank command
   always_comb begin
      gnt_o = '0;
      if (rst_ni) begin
         if (a_vld) gnt_o[a_id] = 1'b1;
         if (b_vld) gnt_o[b_id] = 1'b1;
      end
      last_id = b_vld ? b_id : a_id;
      ptr_d   = ptr_q;
      if (a_vld) begin
         ptr_d = (last_id == IDW'(NUM_REQ-1)) ? '0 : last_id + 1'b1;
      end
      bank_addr_a_d = a_vld ? addr_w[a_id]  : '0;
      bank_din_a_d  = a_vld ? wdata_w[a_id] : '0;
      bank_we_a_d   = a_vld & req_we_i[a_id];
      bank_addr_b_d = b_vld ? addr_w[b_id]  : '0;
      bank_din_b_d  = b_vld ? wdata_w[b_id] : '0;
      bank_we_b_d   = b_vld & req_we_i[b_id];
   end

   // pointer and bank command registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q         <= '0;
         bank_addr_a_q <= '0;
         bank_din_a_q  <= '0;
         bank_we_a_q   <= 1'b0;
         bank_addr_b_q <= '0;
         bank_din_b_q  <= '0;
         bank_we_b_q   <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         bank_addr_a_q <= bank_addr_a_d;
         bank_din_a_q  <= bank_din_a_d;
         bank_we_a_q   <= bank_we_a_d;
         bank_addr_b_q <= bank_addr_b_d;
         bank_din_b_q  <= bank_din_b_d;
         bank_we_b_q   <= bank_we_b_d;
      end
   end

   // decode the oldest tag stage into per-requester response controls
   always_comb begin
      rsp_valid_d  = '0;
      rsp_from_b_d = '0;
      rsp_rd_d     = '0;
      if (tag_a_vld_q[RD_LAT-1]) begin
         rsp_valid_d[tag_a_id_q[RD_LAT-1]] = 1'b1;
         rsp_rd_d[tag_a_id_q[RD_LAT-1]]    = !tag_a_we_q[RD_LAT-1];
      end
      if (tag_b_vld_q[RD_LAT-1]) begin
         rsp_valid_d[tag_b_id_q[RD_LAT-1]]  = 1'b1;
         rsp_from_b_d[tag_b_id_q[RD_LAT-1]] = 1'b1;
         rsp_rd_d[tag_b_id_q[RD_LAT-1]]     = !tag_b_we_q[RD_LAT-1];
      end
   end

   // tag pipeline shift; reset drops everything in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < RD_LAT; s++) begin
            tag_a_vld_q[s] <= 1'b0;
            tag_a_we_q[s]  <= 1'b0;
            tag_a_id_q[s]  <= '0;
            tag_b_vld_q[s] <= 1'b0;
            tag_b_we_q[s]  <= 1'b0;
            tag_b_id_q[s]  <= '0;
         end
         rsp_valid_q  <= '0;
         rsp_from_b_q <= '0;
         rsp_rd_q     <= '0;
      end else begin
         tag_a_vld_q[0] <= a_vld;
         tag_a_we_q[0]  <= req_we_i[a_id];
         tag_a_id_q[0]  <= a_id;
         tag_b_vld_q[0] <= b_vld;
         tag_b_we_q[0]  <= req_we_i[b_id];
         tag_b_id_q[0]  <= b_id;
         for (int s = 1; s < RD_LAT; s++) begin
            tag_a_vld_q[s] <= tag_a_vld_q[s-1];
            tag_a_we_q[s]  <= tag_a_we_q[s-1];
            tag_a_id_q[s]  <= tag_a_id_q[s-1];
            tag_b_vld_q[s] <= tag_b_vld_q[s-1];
            tag_b_we_q[s]  <= tag_b_we_q[s-1];
            tag_b_id_q[s]  <= tag_b_id_q[s-1];
         end
         rsp_valid_q  <= rsp_valid_d;
         rsp_from_b_q <= rsp_from_b_d;
         rsp_rd_q     <= rsp_rd_d;
      end
   end

   // read data is taken from the owning port in the response cycle; writes return 0
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
         (rsp_valid_q[gi] && rsp_rd_q[gi]) ? (rsp_from_b_q[gi] ? bank_dout_b_i : bank_dout_a_i)
                                           : '0;
   end

   assign rsp_valid_o   = rsp_valid_q;
   assign bank_addr_a_o = bank_addr_a_q;
   assign bank_din_a_o  = bank_din_a_q;
   assign bank_we_a_o   = bank_we_a_q;
   assign bank_addr_b_o = bank_addr_b_q;
   assign bank_din_b_o  = bank_din_b_q;
   assign bank_we_b_o   = bank_we_b_q;

`ifdef CACHE_ARB_PERF_EN
   // saturating count of cycles where a port-B candidate was skipped for a hazard
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_cnt_q <= '0;
      end else if (hazard_skip && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
   end
   assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Self-checking bench for cache_bank_arbiter (default parameters, RD_LAT=1).
// A bank memory model answers the DUT's bank ports; a scoreboard model predicts
// grants, bank commands and responses every cycle. Build with CACHE_ARB_PERF_EN
// defined to also check conflict_cnt_o.
module tb_cache_bank_arbiter;
   localparam int N      = 4;
   localparam int DW     = 8;
   localparam int AW     = 8;
   localparam int RD_LAT = 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0, req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    gnt, rsp_valid;
   logic [N*DW-1:0] rsp_data;
   logic [AW-1:0]   bank_addr_a, bank_addr_b;
   logic [DW-1:0]   bank_din_a, bank_din_b;
   logic            bank_we_a, bank_we_b;
   logic [DW-1:0]   bank_dout_a = '0, bank_dout_b = '0;
`ifdef CACHE_ARB_PERF_EN
   logic [15:0]     conflict_cnt;
`endif

   int checks = 0;
   int errors = 0;

   cache_bank_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .bank_addr_a_o(bank_addr_a), .bank_addr_b_o(bank_addr_b),
      .bank_din_a_o(bank_din_a), .bank_din_b_o(bank_din_b),
      .bank_we_a_o(bank_we_a), .bank_we_b_o(bank_we_b),
      .bank_dout_a_i(bank_dout_a), .bank_dout_b_i(bank_dout_b)
`ifdef CACHE_ARB_PERF_EN
      , .conflict_cnt_o(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- bank memory (read-before-write, one cycle latency) ----------
   logic [DW-1:0] mem   [256];
   logic [DW-1:0] m_mem [256];

   always @(posedge clk) begin
      bank_dout_a <= mem[bank_addr_a];
      bank_dout_b <= mem[bank_addr_b];
      if (bank_we_a) mem[bank_addr_a] <= bank_din_a;
      if (bank_we_b) mem[bank_addr_b] <= bank_din_b;
   end

   // ---------------- requester queues and driver --------------------------------
   logic [AW-1:0] q_addr [N][16];
   logic [DW-1:0] q_data [N][16];
   logic          q_we   [N][16];
   int            qh [N];
   int            qt [N];
   logic [N-1:0]  gnt_last = '0;

   task automatic push(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
      q_we[i][qt[i] % 16]   = we;
      q_addr[i][qt[i] % 16] = a;
      q_data[i][qt[i] % 16] = d;
      qt[i]++;
   endtask

   // hold each request until its grant is seen, then present the next one
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (gnt_last[i]) qh[i]++;
         if (qh[i] != qt[i]) begin
            req[i]               = 1'b1;
            req_we[i]            = q_we[i][qh[i] % 16];
            req_addr[i*AW +: AW] = q_addr[i][qh[i] % 16];
            req_wdata[i*DW +: DW] = q_data[i][qh[i] % 16];
         end else begin
            req[i] = 1'b0;
         end
      end
   end

   // ---------------- scoreboard model and per-cycle compare ----------------------
   logic [N-1:0]    ev [8];
   logic [N*DW-1:0] ed [8];
   int              cyc = 0;
   int              m_ptr = 0;
   logic [15:0]     m_cnt = '0;
   logic [AW-1:0]   m_baa = '0, m_bab = '0;
   logic [DW-1:0]   m_bda = '0, m_bdb = '0;
   logic            m_bwa = 1'b0, m_bwb = 1'b0;

   always @(negedge clk) begin
      int slot, ns, ga, gb, idx;
      bit skip;
      logic [N-1:0] eg;
      slot = cyc % 8;
      if (!rst_n) begin
         for (int s = 0; s < 8; s++) begin
            ev[s] = '0;
            ed[s] = '0;
         end
         m_ptr = 0; m_cnt = '0;
         m_baa = '0; m_bab = '0; m_bda = '0; m_bdb = '0; m_bwa = 1'b0; m_bwb = 1'b0;
         check("gnt_in_reset", gnt, '0);
         check("rsp_valid_in_reset", rsp_valid, '0);
      end else begin
         check("rsp_valid", rsp_valid, ev[slot]);
         check("rsp_data", rsp_data, ed[slot]);
         ev[slot] = '0;
         ed[slot] = '0;
         check("bank_a", {bank_we_a, bank_addr_a, bank_din_a}, {m_bwa, m_baa, m_bda});
         check("bank_b", {bank_we_b, bank_addr_b, bank_din_b}, {m_bwb, m_bab, m_bdb});
`ifdef CACHE_ARB_PERF_EN
         check("conflict_cnt", conflict_cnt, m_cnt);
`endif
         // round robin from m_ptr: first pending -> A, first hazard-free after it -> B
         ga = -1; gb = -1; skip = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req[idx]) begin
               if (ga < 0) ga = idx;
               else if (gb < 0) begin
                  if (req_addr[idx*AW +: AW] == req_addr[ga*AW +: AW] && (req_we[idx] || req_we[ga]))
                     skip = 1'b1;
                  else
                     gb = idx;
               end
            end
         end
         eg = '0;
         if (ga >= 0) eg[ga] = 1'b1;
         if (gb >= 0) eg[gb] = 1'b1;
         check("gnt", gnt, eg);

         ns = (cyc + 1 + RD_LAT) % 8;
         m_bwa = 1'b0; m_baa = '0; m_bda = '0;
         m_bwb = 1'b0; m_bab = '0; m_bdb = '0;
         if (ga >= 0) begin
            ev[ns][ga] = 1'b1;
            ed[ns][ga*DW +: DW] = req_we[ga] ? '0 : m_mem[req_addr[ga*AW +: AW]];
            m_bwa = req_we[ga]; m_baa = req_addr[ga*AW +: AW]; m_bda = req_wdata[ga*DW +: DW];
         end
         if (gb >= 0) begin
            ev[ns][gb] = 1'b1;
            ed[ns][gb*DW +: DW] = req_we[gb] ? '0 : m_mem[req_addr[gb*AW +: AW]];
            m_bwb = req_we[gb]; m_bab = req_addr[gb*AW +: AW]; m_bdb = req_wdata[gb*DW +: DW];
         end
         if (m_bwa) m_mem[m_baa] = m_bda;
         if (m_bwb) m_mem[m_bab] = m_bdb;
         if (gb >= 0) m_ptr = (gb + 1) % N;
         else if (ga >= 0) m_ptr = (ga + 1) % N;
         if (skip && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      gnt_last = gnt;
      cyc++;
   end

   // ---------------- directed stimulus -----------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   logic [N-1:0] fair_g [8];
   int           fair_cnt [N];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'(i) ^ 8'hA5;
      end
      mem[4] = 8'h02;
      mem[1] = 8'h5A;
      for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
      for (int i = 0; i < N; i++) begin
         qh[i] = 0;
         qt[i] = 0;
      end

      // reset state
      repeat (3) step();
      check("rst_gnt", gnt, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_bank_we", {bank_we_a, bank_we_b}, 2'b00);
      rst_n = 1'b1;
      step();
      $display("txn reset: outputs idle");

      // single read
      push(0, 1'b0, 8'h04, 8'h00);
      step();
      check("single_gnt", gnt, 4'b0001);
      step();
      check("single_bank_addr_a", bank_addr_a, 8'h04);
      step();
      check("single_rsp_valid", rsp_valid, 4'b0001);
      check("single_rsp_data0", rsp_data[7:0], 8'h02);
      $display("txn single read r0 addr 04 -> data %0h", rsp_data[7:0]);
      step();

      // dual grant from ptr 0
      do_reset();
      for (int i = 0; i < N; i++) push(i, 1'b0, 8'(8'h10 + i), 8'h00);
      step();
      check("dual_gnt0", gnt, 4'b0011);
      step();
      check("dual_gnt1", gnt, 4'b1100);
      $display("txn dual grant: 0011 then 1100");
      step();
      step();

      // write hazard (ptr is back at 0)
      push(0, 1'b1, 8'h06, 8'h03);
      push(1, 1'b0, 8'h06, 8'h00);
      push(2, 1'b0, 8'h07, 8'h00);
      step();
      check("hazard_gnt0", gnt, 4'b0101);
      step();
      check("hazard_gnt1", gnt, 4'b0010);
`ifdef CACHE_ARB_PERF_EN
      check("hazard_conflict_cnt", conflict_cnt, 16'd1);
`endif
      step();
      step();
      check("hazard_rsp_valid", rsp_valid, 4'b0010);
      check("hazard_rsp_data1", rsp_data[15:8], 8'h03);
      $display("txn write hazard: r1 read after r0 write -> %0h", rsp_data[15:8]);
      step();

      // same-address reads
      push(0, 1'b0, 8'h01, 8'h00);
      push(1, 1'b0, 8'h01, 8'h00);
      step();
      check("same_addr_gnt", gnt, 4'b0011);
      step();
      step();
      check("same_addr_rsp_valid", rsp_valid, 4'b0011);
      check("same_addr_data", {rsp_data[15:8], rsp_data[7:0]}, {8'h5A, 8'h5A});
      $display("txn same-address reads: %0h %0h", rsp_data[15:8], rsp_data[7:0]);
      step();

      // fairness: all four held for 8 cycles
      for (int i = 0; i < N; i++) begin
         fair_cnt[i] = 0;
         for (int k = 0; k < 4; k++) push(i, 1'b0, 8'(8'h20 + i*4 + k), 8'h00);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         fair_g[c] = gnt;
         for (int i = 0; i < N; i++) if (gnt[i]) fair_cnt[i]++;
      end
      for (int i = 0; i < N; i++) check($sformatf("fair_count_r%0d", i), 64'(fair_cnt[i]), 64'd4);
      for (int c = 0; c < 7; c++) check($sformatf("fair_window_%0d", c), fair_g[c] | fair_g[c+1], 4'b1111);
      $display("txn fairness: counts %0d %0d %0d %0d", fair_cnt[0], fair_cnt[1], fair_cnt[2], fair_cnt[3]);
      step();
      step();

      // reset mid-flight
      push(0, 1'b0, 8'h04, 8'h00);
      step();
      check("midrst_gnt", gnt, 4'b0001);
      step();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("midrst_no_rsp", rsp_valid, '0);
      end
      rst_n = 1'b1;
      step();
      check("midrst_bank_we", {bank_we_a, bank_we_b}, 2'b00);
      for (int i = 0; i < N; i++) push(i, 1'b0, 8'(8'h40 + i), 8'h00);
      step();
      check("midrst_ptr0_gnt", gnt, 4'b0011);
      $display("txn reset mid-flight: response dropped, ptr restarted");
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
